// File: rtl/ama_riscv_mmio_pkg.sv
// Shared types and constants for the MMIO peripheral block and its UART.
package ama_riscv_mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_FRAME_BITS = 10;

  // Word indices of the MMIO register window as seen by the core
  localparam logic [2:0] MMIO_CTRL    = 3'd0;
  localparam logic [2:0] MMIO_RX_DATA = 3'd1;
  localparam logic [2:0] MMIO_TX_DATA = 3'd2;
  localparam logic [2:0] MMIO_CNT_RST = 3'd4;
  localparam logic [2:0] MMIO_CYCLE   = 3'd5;
  localparam logic [2:0] MMIO_INSTR   = 3'd6;

endpackage

// File: rtl/ama_riscv_uart.sv
// 8N1 UART transmitter and receiver with independent baud counters.
// Define AMA_RISCV_UART_LOOPBACK_EN to feed the receiver from serial_out.
module ama_riscv_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_idle,
  output logic       rx_done,
  output logic [7:0] rx_data,
  input  logic       serial_in,
  output logic       serial_out
);
  import ama_riscv_mmio_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_state_t      tx_state_reg, tx_state_next;
  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic             tx_out_reg, tx_out_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_out_reg   <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_out_reg   <= tx_out_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + 1'b1;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_out_next   = tx_out_reg;
    case (tx_state_reg)
      IDLE: begin
        tx_cnt_next = '0;
        tx_out_next = 1'b1;
        if (tx_start) begin
          tx_state_next = START;
          tx_shift_next = tx_data;
          tx_out_next   = 1'b0;
        end
      end
      START: if (tx_cnt_reg == BIT_LAST) begin
        tx_state_next = DATA;
        tx_cnt_next   = '0;
        tx_bit_next   = '0;
        tx_out_next   = tx_shift_reg[0];
      end
      DATA: if (tx_cnt_reg == BIT_LAST) begin
        tx_cnt_next = '0;
        if (tx_bit_reg == 3'd7) begin
          tx_state_next = STOP;
          tx_out_next   = 1'b1;
        end else begin
          tx_bit_next   = tx_bit_reg + 1'b1;
          tx_shift_next = tx_shift_reg >> 1;
          tx_out_next   = tx_shift_reg[1];
        end
      end
      STOP: if (tx_cnt_reg == BIT_LAST) begin
        tx_state_next = IDLE;
        tx_cnt_next   = '0;
      end
      default: tx_state_next = IDLE;
    endcase
  end

  assign tx_idle    = (tx_state_reg == IDLE);
  assign serial_out = tx_out_reg;

  logic rx_src;
`ifdef AMA_RISCV_UART_LOOPBACK_EN
  logic unused_serial_in;
  assign unused_serial_in = serial_in;
  assign rx_src = tx_out_reg;
`else
  assign rx_src = serial_in;
`endif

  logic             rx_sync1_reg, rx_sync2_reg;
  uart_state_t      rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync1_reg <= 1'b1;
      rx_sync2_reg <= 1'b1;
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_sync1_reg <= rx_src;
      rx_sync2_reg <= rx_sync1_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // Start is re-checked at half a bit so that all later samples land mid-bit
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + 1'b1;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        rx_cnt_next = '0;
        if (!rx_sync2_reg) rx_state_next = START;
      end
      START: if (rx_cnt_reg == HALF_LAST) begin
        rx_cnt_next   = '0;
        rx_bit_next   = '0;
        rx_state_next = rx_sync2_reg ? IDLE : DATA;
      end
      DATA: if (rx_cnt_reg == BIT_LAST) begin
        rx_cnt_next   = '0;
        rx_shift_next = {rx_sync2_reg, rx_shift_reg[7:1]};
        if (rx_bit_reg == 3'd7) rx_state_next = STOP;
        else                    rx_bit_next   = rx_bit_reg + 1'b1;
      end
      STOP: if (rx_cnt_reg == BIT_LAST) begin
        rx_state_next = IDLE;
        rx_cnt_next   = '0;
        rx_done       = rx_sync2_reg;
      end
      default: rx_state_next = IDLE;
    endcase
  end

  assign rx_data = rx_shift_reg;

endmodule

// File: rtl/ama_riscv_mmio.sv
// MMIO peripheral block: cycle/instruction counters, core UART handshake and
// the UART itself. AMA_RISCV_UART_LOOPBACK_EN loops TX back into RX.
module ama_riscv_mmio #(
  parameter int CLOCK_FREQ   = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_to_uart,
  input  logic        load_from_uart,
  input  logic [7:0]  mmio_uart_data_in,
  input  logic        mmio_reset_cnt,
  input  logic        inst_wb_nop_or_clear,
  output logic [31:0] mmio_cycle_cnt,
  output logic [31:0] mmio_instr_cnt,
  output logic [7:0]  mmio_uart_data_out,
  output logic        mmio_data_out_valid,
  output logic        mmio_data_in_ready,
  input  logic        serial_in,
  output logic        serial_out
);
  import ama_riscv_mmio_pkg::*;

  logic [31:0] cycle_cnt_reg, instr_cnt_reg;
  logic        tx_pending_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_valid_reg;
  logic        tx_idle, rx_done;
  logic [7:0]  rx_byte;

  // The store strobe leads its data by one cycle, so the byte is taken from
  // mmio_uart_data_in on the edge after the strobe (tx_pending_reg high).
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_reg  <= '0;
      instr_cnt_reg  <= '0;
      tx_pending_reg <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
    end else begin
      cycle_cnt_reg <= mmio_reset_cnt ? 32'd0 : cycle_cnt_reg + 32'd1;
      if (mmio_reset_cnt)             instr_cnt_reg <= '0;
      else if (!inst_wb_nop_or_clear) instr_cnt_reg <= instr_cnt_reg + 32'd1;

      if (store_to_uart && mmio_data_in_ready) tx_pending_reg <= 1'b1;
      else                                     tx_pending_reg <= 1'b0;

      if (rx_done) begin
        rx_data_reg  <= rx_byte;
        rx_valid_reg <= 1'b1;
      end else if (load_from_uart) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  ama_riscv_uart #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_pending_reg),
    .tx_data    (mmio_uart_data_in),
    .tx_idle    (tx_idle),
    .rx_done    (rx_done),
    .rx_data    (rx_byte),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  assign mmio_cycle_cnt      = cycle_cnt_reg;
  assign mmio_instr_cnt      = instr_cnt_reg;
  assign mmio_uart_data_out  = rx_data_reg;
  assign mmio_data_out_valid = rx_valid_reg;
  assign mmio_data_in_ready  = !tx_pending_reg && tx_idle;

endmodule

// File: tb/tb_ama_riscv_mmio.sv
// Scoreboard bench for ama_riscv_mmio: serial frames decoded by monitors and
// compared against byte queues filled when stimulus is issued.
module tb_ama_riscv_mmio;
  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int CPB        = CLOCK_FREQ / BAUD_RATE;
`ifdef AMA_RISCV_UART_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, store_to_uart, load_from_uart, mmio_reset_cnt;
  logic        inst_wb_nop_or_clear, serial_in;
  logic [7:0]  mmio_uart_data_in;
  logic [31:0] mmio_cycle_cnt, mmio_instr_cnt;
  logic [7:0]  mmio_uart_data_out;
  logic        mmio_data_out_valid, mmio_data_in_ready, serial_out;

  always #5 clk = ~clk;

  ama_riscv_mmio #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .store_to_uart        (store_to_uart),
    .load_from_uart       (load_from_uart),
    .mmio_uart_data_in    (mmio_uart_data_in),
    .mmio_reset_cnt       (mmio_reset_cnt),
    .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
    .mmio_cycle_cnt       (mmio_cycle_cnt),
    .mmio_instr_cnt       (mmio_instr_cnt),
    .mmio_uart_data_out   (mmio_uart_data_out),
    .mmio_data_out_valid  (mmio_data_out_valid),
    .mmio_data_in_ready   (mmio_data_in_ready),
    .serial_in            (serial_in),
    .serial_out           (serial_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // TX monitor: decode each frame mid-bit and check ready across the frame
  initial begin
    logic       prev;
    logic [9:0] bits;
    logic       ready_low;
    logic [7:0] want;
    prev = 1'b1;
    forever begin
      tick(1);
      if (!rst && prev && !serial_out) begin
        ready_low = 1'b1;
        for (int off = 0; off < 10 * CPB; off++) begin
          if (off % CPB == CPB / 2) bits[off / CPB] = serial_out;
          if (mmio_data_in_ready !== 1'b0) ready_low = 1'b0;
          tick(1);
        end
        check("tx_frame_expected", 32'(tx_exp.size() > 0), 32'd1);
        want = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
        check("tx_start_bit", 32'(bits[0]), 32'd0);
        check("tx_data", 32'(bits[8:1]), 32'(want));
        check("tx_stop_bit", 32'(bits[9]), 32'd1);
        check("tx_ready_low_in_frame", 32'(ready_low), 32'd1);
        check("tx_ready_after_frame", 32'(mmio_data_in_ready), 32'd1);
        $display("tx frame 0x%02h (expected 0x%02h)", bits[8:1], want);
      end
      prev = serial_out;
    end
  end

  // RX monitor: a byte is delivered when valid rises or the data changes
  initial begin
    logic       pv;
    logic [7:0] pd, want;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      tick(1);
      if (!rst && mmio_data_out_valid && (!pv || mmio_uart_data_out != pd)) begin
        check("rx_byte_expected", 32'(rx_exp.size() > 0), 32'd1);
        want = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'hxx;
        check("rx_byte", 32'(mmio_uart_data_out), 32'(want));
        $display("rx byte 0x%02h (expected 0x%02h)", mmio_uart_data_out, want);
      end
      pv = mmio_data_out_valid;
      pd = mmio_uart_data_out;
    end
  end

  task automatic tx_byte(input logic [7:0] b);
    int w = 0;
    while (!mmio_data_in_ready && w < 400) begin tick(1); w++; end
    check("tx_ready_before_store", 32'(mmio_data_in_ready), 32'd1);
    store_to_uart = 1'b1;
    mmio_uart_data_in = ~b;
    tick(1);
    check("tx_ready_drop", 32'(mmio_data_in_ready), 32'd0);
    store_to_uart = 1'b0;
    mmio_uart_data_in = b;
    tx_exp.push_back(b);
    if (LOOPBACK) begin
      rx_exp.push_back(b);
      exp_data  = b;
      exp_valid = 1'b1;
    end
    tick(1);
    mmio_uart_data_in = ~b;
  endtask

  task automatic tx_wait_done();
    int w = 0;
    while ((tx_exp.size() != 0 || !mmio_data_in_ready) && w < 400) begin tick(1); w++; end
    check("tx_done_timeout", 32'(w < 400), 32'd1);
    tick(4);
  endtask

  task automatic rx_load();
    check("rx_valid_before_load", 32'(mmio_data_out_valid), 32'(exp_valid));
    check("rx_data_before_load", 32'(mmio_uart_data_out), 32'(exp_data));
    load_from_uart = 1'b1;
    tick(1);
    load_from_uart = 1'b0;
    exp_valid = 1'b0;
    check("rx_valid_after_load", 32'(mmio_data_out_valid), 32'd0);
    check("rx_data_after_load", 32'(mmio_uart_data_out), 32'(exp_data));
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    if (stop) rx_exp.push_back(b);
    serial_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin serial_in = b[i]; tick(CPB); end
    serial_in = stop;
    tick(CPB);
    serial_in = 1'b1;
    if (stop) begin exp_data = b; exp_valid = 1'b1; end
    tick(CPB);
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1; store_to_uart = 1'b0; load_from_uart = 1'b0;
    mmio_reset_cnt = 1'b0; inst_wb_nop_or_clear = 1'b1;
    mmio_uart_data_in = 8'h00; serial_in = !LOOPBACK;
    tick(2);
    rst = 1'b0;
    check("rst_cycle_cnt", mmio_cycle_cnt, 32'd0);
    check("rst_instr_cnt", mmio_instr_cnt, 32'd0);
    check("rst_data_out", 32'(mmio_uart_data_out), 32'd0);
    check("rst_valid", 32'(mmio_data_out_valid), 32'd0);
    check("rst_ready", 32'(mmio_data_in_ready), 32'd1);
    check("rst_serial_out", 32'(serial_out), 32'd1);
    tick(100);
    check("cycle_after_100", mmio_cycle_cnt, 32'd100);
    check("idle_serial_out", 32'(serial_out), 32'd1);

    inst_wb_nop_or_clear = 1'b0; tick(7);
    inst_wb_nop_or_clear = 1'b1; tick(3);
    check("instr_7_of_10", mmio_instr_cnt, 32'd7);
    // reset_cnt wins even over a retiring instruction
    mmio_reset_cnt = 1'b1; inst_wb_nop_or_clear = 1'b0; tick(2);
    check("cnt_rst_cycle", mmio_cycle_cnt, 32'd0);
    check("cnt_rst_instr", mmio_instr_cnt, 32'd0);
    mmio_reset_cnt = 1'b0; tick(1);
    check("cnt_resume_cycle", mmio_cycle_cnt, 32'd1);
    check("cnt_resume_instr", mmio_instr_cnt, 32'd1);
    inst_wb_nop_or_clear = 1'b1; tick(4);
    check("cnt_resume_cycle_5", mmio_cycle_cnt, 32'd5);
    check("cnt_hold_instr", mmio_instr_cnt, 32'd1);

    // 0xA5 with a second store mid-frame that must be dropped
    tx_byte(8'hA5);
    tick(30);
    store_to_uart = 1'b1; mmio_uart_data_in = 8'h33; tick(1);
    store_to_uart = 1'b0; tick(1);
    check("tx_busy_store_ready", 32'(mmio_data_in_ready), 32'd0);
    tx_wait_done();
    tick(150);
    check("tx_no_extra_frame", 32'(tx_exp.size()), 32'd0);
    rx_load();
    for (int k = 0; k < 3; k++) begin
      r = 8'($urandom_range(0, 255));
      tx_byte(r);
      tx_wait_done();
      rx_load();
    end

`ifndef AMA_RISCV_UART_LOOPBACK_EN
    rx_frame(8'h3C, 1'b1);
    rx_load();
    serial_in = 1'b0; tick(3);
    serial_in = 1'b1; tick(3 * CPB);
    check("glitch_no_byte", 32'(mmio_data_out_valid), 32'd0);
    rx_frame(8'h55, 1'b0);
    tick(CPB);
    check("framing_valid", 32'(mmio_data_out_valid), 32'd0);
    check("framing_data", 32'(mmio_uart_data_out), 32'h3C);
    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom_range(0, 255));
      rx_frame(r, 1'b1);
      rx_load();
    end
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    check("overrun_data", 32'(mmio_uart_data_out), 32'h22);
    check("overrun_valid", 32'(mmio_data_out_valid), 32'd1);
`endif

    tick(20);
    check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
